mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer for the single-cycle MIPS datapath. It shares one external memory port between instruction fetch and data load/store, and holds the fetched instruction and load data stable for the datapath. It emits the per-instruction enable pulse that advances the datapath, so each instruction takes as many cycles as memory needs. It sits between the datapath and the memory subsystem and replaces the direct `cpu_en` connection.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles a memory request may wait for `ext_ack`; used only with the timeout feature. Range 1..255.

Ports:
- `clk` in 1: the block's one clock; every register updates on its rising edge.
- `cpu_rst` in 1: reset; synchronous, active-high.
- `cpu_en` in 1: run enable from the debug control.
- `cpu_step` out 1: one-cycle enable pulse to the datapath; PC and regfile update on this pulse.
- `inst_addr` in 32: PC from the datapath.
- `inst_data` out 32: latched instruction.
- `mem_ren` in 1: datapath load request, decoded from `inst_data`.
- `mem_wen` in 1: datapath store request, decoded from `inst_data`.
- `mem_addr` in 32: datapath data address.
- `mem_dout` in 32: datapath store data.
- `mem_din` out 32: latched load data.
- `ext_req` out 1: memory request.
- `ext_we` out 1: memory write strobe, valid while `ext_req` is high.
- `ext_addr` out 32: memory address.
- `ext_wdata` out 32: memory write data.
- `ext_rdata` in 32: memory read data, valid when `ext_ack` is high.
- `ext_ack` in 1: memory completion, one cycle per request.
- `retired` out 32: count of completed instructions.
- `bus_err` out 1: sticky timeout flag.
- `arb_state` out 3: current FSM state, for debug.

## Operation
FSM states, each with its encoding and behaviour:
- IDLE=0: no request. Moves to FETCH when `cpu_en`=1.
- FETCH=1: `ext_req`=1, `ext_we`=0, `ext_addr`=`inst_addr`. On `ext_ack`, latch `ext_rdata` into `inst_data` and move to EXEC.
- EXEC=2: the datapath decodes the latched `inst_data`.
  - If `mem_ren` or `mem_wen` is set, move to DATA.
  - Otherwise assert `cpu_step`, increment `retired`, and move to FETCH if `cpu_en`=1, else to IDLE.
- DATA=3: `ext_req`=1, `ext_we`=`mem_wen`, `ext_addr`=`mem_addr`, `ext_wdata`=`mem_dout`. On `ext_ack`:
  - for a read, latch `ext_rdata` into `mem_din`;
  - for a write, leave `mem_din` unchanged;
  - then move to COMMIT.
- COMMIT=4: assert `cpu_step`, increment `retired`, and move to FETCH if `cpu_en`=1, else to IDLE.
- HALT=5: entered only by timeout. No requests are issued. Left only via `cpu_rst`.

Output and arithmetic rules:
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata` and `cpu_step` are combinational functions of the state and the datapath inputs.
- `ext_addr` and `ext_wdata` are 0 when `ext_req`=0.
- If `mem_ren` and `mem_wen` are both set, it is treated as a write.
- `retired` wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values: state IDLE, `inst_data`=0 (NOP), `mem_din`=0, `retired`=0, `bus_err`=0, `ext_req`=0, `cpu_step`=0.
- Reset during a request: `ext_req` is low in the cycle after the reset edge. The memory must tolerate an abandoned request. A late `ext_ack` is ignored.
- Handshake rules:
  - `ext_req`, `ext_addr`, `ext_wdata` and `ext_we` stay stable until the edge on which `ext_ack` is sampled high.
  - Zero-wait memory may assert `ext_ack` in the same cycle that `ext_req` rises.
  - `ext_ack` is ignored in IDLE, EXEC, COMMIT and HALT.
- Latency with zero-wait memory:
  - ALU or branch instruction: 2 cycles (FETCH, EXEC).
  - Load or store: 4 cycles (FETCH, EXEC, DATA, COMMIT).
  - Each wait cycle on `ext_ack` adds one cycle.
- `cpu_en` dropping mid-instruction does not abort the instruction. It completes, and the FSM then parks in IDLE.
- `cpu_step` is never high for two consecutive cycles.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to FETCH or DATA and increments each cycle with no `ext_ack`.
  - When the counter reaches `TIMEOUT_CYCLES` without ack, `bus_err` is set, the FSM enters HALT, and `ext_req` drops on the next cycle.
  - An `ext_ack` arriving in the same cycle as the terminal count wins: the transfer completes and there is no error.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - The FSM waits indefinitely in FETCH or DATA.
  - `bus_err` is tied to 0 and HALT is unreachable.

## Test plan
- Reset, then `cpu_en`=1 with zero-wait memory and `inst_addr`=0 returning 0x20080005 (addi) → `ext_req` high in cycle 1, `cpu_step` pulse in cycle 2, `retired`=1, back in FETCH.
- Load `lw` with `mem_ren`=1, `mem_addr`=0x100, memory returning 0xDEADBEEF after 3 wait cycles → DATA held for 4 cycles with address stable, `mem_din`=0xDEADBEEF before the COMMIT `cpu_step`.
- Store with `mem_wen`=1, `mem_addr`=0x40, `mem_dout`=0x12345678 → one request with `ext_we`=1 and exact address/data, `mem_din` unchanged, `retired`+1.
- `cpu_en` dropped during DATA → the store completes, one `cpu_step` is issued, the FSM stays in IDLE with no further `ext_req`; raising `cpu_en` again resumes FETCH.
- `cpu_rst` asserted while FETCH is waiting → next cycle `ext_req`=0, state IDLE, `retired`=0, `inst_data`=0; an ack the following cycle has no effect.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → `bus_err`=1 after 4 waiting cycles, HALT (`arb_state`=5) until `cpu_rst`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access and paces the
// single-cycle datapath with cpu_step. Define ARB_TIMEOUT_EN to build the request timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        cpu_en,
  output logic        cpu_step,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack,
  output logic [31:0] retired,
  output logic        bus_err,
  output logic [2:0]  arb_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_inst;
  logic [31:0] r_din;
  logic [31:0] r_retired;
  logic        w_mem_op;
  logic        w_timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign w_mem_op = mem_ren | mem_wen;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait;
  logic       r_bus_err;

  // Counter idles at zero outside FETCH/DATA, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (cpu_rst || ext_ack || !(r_state == S_FETCH || r_state == S_DATA))
      r_wait <= '0;
    else
      r_wait <= r_wait + 8'd1;
  end

  assign w_timeout = (r_state == S_FETCH || r_state == S_DATA) && !ext_ack && (r_wait == LP_LAST);

  always_ff @(posedge clk) begin
    if (cpu_rst)
      r_bus_err <= 1'b0;
    else if (w_timeout)
      r_bus_err <= 1'b1;
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (cpu_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (cpu_en) w_next = S_FETCH;
      S_FETCH:  if (ext_ack) w_next = S_EXEC;
                else if (w_timeout) w_next = S_HALT;
      S_EXEC:   if (w_mem_op) w_next = S_DATA;
                else w_next = cpu_en ? S_FETCH : S_IDLE;
      S_DATA:   if (ext_ack) w_next = S_COMMIT;
                else if (w_timeout) w_next = S_HALT;
      S_COMMIT: w_next = cpu_en ? S_FETCH : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
    cpu_step  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        ext_req  = 1'b1;
        ext_addr = inst_addr;
      end
      S_EXEC:   cpu_step = ~w_mem_op;
      S_DATA: begin
        ext_req   = 1'b1;
        ext_we    = mem_wen;
        ext_addr  = mem_addr;
        ext_wdata = mem_dout;
      end
      S_COMMIT: cpu_step = 1'b1;
      default: ;
    endcase
  end

  // A combined read+write request is a write, so load data latches only without mem_wen.
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      r_inst    <= '0;
      r_din     <= '0;
      r_retired <= '0;
    end else begin
      if (r_state == S_FETCH && ext_ack)
        r_inst <= ext_rdata;
      if (r_state == S_DATA && ext_ack && !mem_wen)
        r_din <= ext_rdata;
      if (cpu_step)
        r_retired <= r_retired + 32'd1;
    end
  end

  assign inst_data = r_inst;
  assign mem_din   = r_din;
  assign retired   = r_retired;
  assign arb_state = r_state;

endmodule
